// File: rtl/trap_ctrl_pkg.sv
// Shared types and constants for the trap/mret sequencer.
package trap_ctrl_pkg;

    typedef enum logic [1:0] {
        TS_IDLE,
        TS_WAIT_MEM,
        TS_COMMIT,
        TS_REDIRECT
    } trap_state_t;

    typedef enum logic [1:0] {
        TK_EXC,
        TK_IRQ,
        TK_MRET
    } trap_kind_t;

    localparam logic [31:0] IRQ_CAUSE_MTI       = 32'h8000_0007;
    localparam logic [1:0]  MTVEC_MODE_VECTORED = 2'b01;

endpackage

// File: rtl/trap_target_calc.sv
// Fetch redirect target: trap vector (direct or vectored) or mepc for mret.
module trap_target_calc
    import trap_ctrl_pkg::*;
(
    input  trap_kind_t  kind,
    input  logic [31:0] cause,
    input  logic [31:0] mtvec,
    input  logic [31:0] mepc,
    output logic [31:0] redirect_pc
);

    logic [31:0] base;
    logic [31:0] offset;

    assign base   = {mtvec[31:2], 2'b00};
    assign offset = cause << 2;

    always_comb begin
        redirect_pc = base;
        unique case (kind)
            TK_MRET: redirect_pc = mepc;
            TK_IRQ: begin
                // Only interrupts are vectored; exceptions always use the base.
                if (mtvec[1:0] == MTVEC_MODE_VECTORED) redirect_pc = base + offset;
            end
            default: redirect_pc = base;
        endcase
    end

endmodule

// File: rtl/trap_ctrl.sv
// Trap/mret sequencer: arbitrates EX events, drains memory, commits to the CSR file,
// then flushes and redirects fetch.
module trap_ctrl
    import trap_ctrl_pkg::*;
#(
    parameter int unsigned DRAIN_TIMEOUT = 16,
    parameter int unsigned CNT_W         = $clog2(DRAIN_TIMEOUT + 1)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    input  logic [31:0] ex_pc,
    input  logic        ex_exc_valid,
    input  logic [3:0]  ex_exc_code,
    input  logic [31:0] ex_exc_tval,
    input  logic        ex_mret,
    input  logic        mem_busy,
    input  logic        timer_pending,
    input  logic        mie_mtie,
    input  logic        mstatus_mie,
    input  logic [31:0] mtvec,
    input  logic [31:0] mepc,
    output logic        trap_enter,
    output logic [31:0] trap_cause,
    output logic [31:0] trap_pc,
    output logic [31:0] trap_val,
    output logic        mret_exec,
    output logic        stall,
    output logic        flush,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        drain_timeout
);

    trap_state_t      state_q, state_d;
    trap_kind_t       kind_q, kind_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      cause_q, cause_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      tval_q, tval_d;
    logic             timeout_q, timeout_d;

    logic        ev_exc, ev_mret, ev_irq, ev_any;
    logic        cnt_last;
    logic [31:0] target_pc;

    assign ev_exc   = ex_valid & ex_exc_valid;
    assign ev_mret  = ex_valid & ex_mret & ~ex_exc_valid;
    assign ev_irq   = ex_valid & timer_pending & mie_mtie & mstatus_mie
                      & ~ex_exc_valid & ~ex_mret;
    assign ev_any   = ev_exc | ev_mret | ev_irq;
    assign cnt_last = (cnt_q == CNT_W'(DRAIN_TIMEOUT - 1));

    trap_target_calc u_target_calc (
        .kind        (kind_q),
        .cause       (cause_q),
        .mtvec       (mtvec),
        .mepc        (mepc),
        .redirect_pc (target_pc)
    );

    always_comb begin
        state_d   = state_q;
        kind_d    = kind_q;
        cnt_d     = cnt_q;
        cause_d   = cause_q;
        pc_d      = pc_q;
        tval_d    = tval_q;
        timeout_d = timeout_q;

        unique case (state_q)
            TS_IDLE: begin
                if (ev_any) begin
                    pc_d    = ex_pc;
                    state_d = mem_busy ? TS_WAIT_MEM : TS_COMMIT;
                    if (ev_exc) begin
                        kind_d  = TK_EXC;
                        cause_d = {28'b0, ex_exc_code};
                        tval_d  = ex_exc_tval;
                    end else if (ev_mret) begin
                        kind_d  = TK_MRET;
                        cause_d = '0;
                        tval_d  = '0;
                    end else begin
                        kind_d  = TK_IRQ;
                        cause_d = IRQ_CAUSE_MTI;
                        tval_d  = '0;
                    end
                end
            end
            TS_WAIT_MEM: begin
                cnt_d = cnt_q + 1'b1;
                if (!mem_busy) begin
                    state_d = TS_COMMIT;
                end else if (cnt_last) begin
                    state_d   = TS_COMMIT;
                    timeout_d = 1'b1;
                end
            end
            TS_COMMIT:   state_d = TS_REDIRECT;
            TS_REDIRECT: begin
                state_d = TS_IDLE;
                cnt_d   = '0;
            end
            default:     state_d = TS_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= TS_IDLE;
            kind_q    <= TK_EXC;
            cnt_q     <= '0;
            cause_q   <= '0;
            pc_q      <= '0;
            tval_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            kind_q    <= kind_d;
            cnt_q     <= cnt_d;
            cause_q   <= cause_d;
            pc_q      <= pc_d;
            tval_q    <= tval_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        trap_enter     = 1'b0;
        mret_exec      = 1'b0;
        trap_cause     = '0;
        trap_pc        = '0;
        trap_val       = '0;
        flush          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        stall          = (state_q != TS_IDLE) | ev_any;
        drain_timeout  = timeout_q;
        if (state_q == TS_COMMIT) begin
            if (kind_q == TK_MRET) begin
                mret_exec = 1'b1;
            end else begin
                trap_enter = 1'b1;
                trap_cause = cause_q;
                trap_pc    = pc_q;
                trap_val   = tval_q;
            end
        end
        if (state_q == TS_REDIRECT) begin
            flush          = 1'b1;
            redirect_valid = 1'b1;
            redirect_pc    = target_pc;
        end
    end

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed self-checking bench for trap_ctrl.
module tb_trap_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic        ex_exc_valid;
    logic [3:0]  ex_exc_code;
    logic [31:0] ex_exc_tval;
    logic        ex_mret;
    logic        mem_busy;
    logic        timer_pending;
    logic        mie_mtie;
    logic        mstatus_mie;
    logic [31:0] mtvec;
    logic [31:0] mepc;
    logic        trap_enter;
    logic [31:0] trap_cause;
    logic [31:0] trap_pc;
    logic [31:0] trap_val;
    logic        mret_exec;
    logic        stall;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        drain_timeout;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    trap_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ex_valid       (ex_valid),
        .ex_pc          (ex_pc),
        .ex_exc_valid   (ex_exc_valid),
        .ex_exc_code    (ex_exc_code),
        .ex_exc_tval    (ex_exc_tval),
        .ex_mret        (ex_mret),
        .mem_busy       (mem_busy),
        .timer_pending  (timer_pending),
        .mie_mtie       (mie_mtie),
        .mstatus_mie    (mstatus_mie),
        .mtvec          (mtvec),
        .mepc           (mepc),
        .trap_enter     (trap_enter),
        .trap_cause     (trap_cause),
        .trap_pc        (trap_pc),
        .trap_val       (trap_val),
        .mret_exec      (mret_exec),
        .stall          (stall),
        .flush          (flush),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .drain_timeout  (drain_timeout)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ex();
        ex_valid      = 1'b0;
        ex_pc         = '0;
        ex_exc_valid  = 1'b0;
        ex_exc_code   = '0;
        ex_exc_tval   = '0;
        ex_mret       = 1'b0;
        timer_pending = 1'b0;
    endtask

    task automatic test_reset();
        clear_ex();
        mem_busy = 0; mie_mtie = 0; mstatus_mie = 0; mtvec = '0; mepc = '0;
        rst_n = 1'b0;
        tick(); tick();
        checks++;
        if ({trap_enter, mret_exec, stall, flush, redirect_valid, drain_timeout} !== 6'b0) begin
            failures++;
            $display("FAIL reset_ctrl got=%b want=000000",
                     {trap_enter, mret_exec, stall, flush, redirect_valid, drain_timeout});
        end
        checks++;
        if ({trap_cause, trap_pc, trap_val, redirect_pc} !== 128'b0) begin
            failures++;
            $display("FAIL reset_data got=%h %h %h %h want=0", trap_cause, trap_pc, trap_val,
                     redirect_pc);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_illegal();
        mtvec = 32'h400;
        ex_valid = 1; ex_exc_valid = 1; ex_exc_code = 4'd2; ex_pc = 32'h100;
        ex_exc_tval = 32'hDEAD;
        #1;
        checks++;
        if (stall !== 1'b1 || trap_enter !== 1'b0) begin
            failures++;
            $display("FAIL ill_detect stall=%b trap_enter=%b want 1 0", stall, trap_enter);
        end
        tick();
        clear_ex();
        #1;
        checks++;
        if (trap_enter !== 1'b1 || trap_cause !== 32'd2 || trap_pc !== 32'h100 ||
            trap_val !== 32'hDEAD || mret_exec !== 1'b0) begin
            failures++;
            $display("FAIL ill_commit te=%b cause=%h pc=%h val=%h me=%b want 1 2 100 dead 0",
                     trap_enter, trap_cause, trap_pc, trap_val, mret_exec);
        end
        tick();
        checks++;
        if (flush !== 1'b1 || redirect_valid !== 1'b1 || redirect_pc !== 32'h400 ||
            trap_enter !== 1'b0 || trap_cause !== 32'd0) begin
            failures++;
            $display("FAIL ill_redirect fl=%b rv=%b rpc=%h te=%b cause=%h want 1 1 400 0 0",
                     flush, redirect_valid, redirect_pc, trap_enter, trap_cause);
        end
        tick();
        checks++;
        if (stall !== 1'b0 || redirect_valid !== 1'b0 || flush !== 1'b0) begin
            failures++;
            $display("FAIL ill_idle stall=%b rv=%b fl=%b want 0 0 0", stall, redirect_valid,
                     flush);
        end
    endtask

    task automatic test_timer_irq();
        mtvec = 32'h801; mie_mtie = 1; mstatus_mie = 1;
        ex_valid = 1; ex_pc = 32'h200; timer_pending = 1;
        tick();
        clear_ex();  // timer drops after detection; irq must still commit
        #1;
        checks++;
        if (trap_enter !== 1'b1 || trap_cause !== 32'h8000_0007 || trap_pc !== 32'h200 ||
            trap_val !== 32'h0) begin
            failures++;
            $display("FAIL irq_commit te=%b cause=%h pc=%h val=%h want 1 80000007 200 0",
                     trap_enter, trap_cause, trap_pc, trap_val);
        end
        tick();
        checks++;
        if (redirect_valid !== 1'b1 || redirect_pc !== 32'h81C) begin
            failures++;
            $display("FAIL irq_redirect rv=%b rpc=%h want 1 81c", redirect_valid, redirect_pc);
        end
        tick();
    endtask

    task automatic test_exc_and_irq();
        int pulses = 0;
        mtvec = 32'h801; mie_mtie = 1; mstatus_mie = 1;
        ex_valid = 1; ex_pc = 32'h300; timer_pending = 1;
        ex_exc_valid = 1; ex_exc_code = 4'd11; ex_exc_tval = 32'h0;
        tick();
        clear_ex();
        timer_pending = 1;
        #1;
        checks++;
        if (trap_enter !== 1'b1 || trap_cause !== 32'd11) begin
            failures++;
            $display("FAIL both_commit te=%b cause=%h want 1 b", trap_enter, trap_cause);
        end
        tick();
        checks++;
        if (redirect_pc !== 32'h800) begin
            failures++;
            $display("FAIL both_redirect rpc=%h want 800", redirect_pc);
        end
        // Timer still pending but ex_valid is low, so no further trap may occur.
        for (int i = 0; i < 4; i++) begin
            tick();
            if (trap_enter === 1'b1) pulses++;
        end
        checks++;
        if (pulses !== 0) begin
            failures++;
            $display("FAIL both_no_irq pulses=%0d want 0", pulses);
        end
        timer_pending = 0;
    endtask

    task automatic test_mret_drain();
        int waits = 0;
        mepc = 32'h344;
        ex_valid = 1; ex_mret = 1; ex_pc = 32'h500; mem_busy = 1;
        tick();
        clear_ex();
        #1;
        while (stall === 1'b1 && mret_exec !== 1'b1 && waits < 10) begin
            waits++;
            if (waits == 2) mem_busy = 1;
            tick();
            if (waits == 2) mem_busy = 0;  // busy high during detect, WAIT1, WAIT2
        end
        checks++;
        if (waits !== 3 || mret_exec !== 1'b1 || trap_enter !== 1'b0) begin
            failures++;
            $display("FAIL mret_wait waits=%0d me=%b te=%b want 3 1 0", waits, mret_exec,
                     trap_enter);
        end
        tick();
        checks++;
        if (redirect_pc !== 32'h344 || redirect_valid !== 1'b1 || drain_timeout !== 1'b0) begin
            failures++;
            $display("FAIL mret_redirect rpc=%h rv=%b dt=%b want 344 1 0", redirect_pc,
                     redirect_valid, drain_timeout);
        end
        tick();
    endtask

    task automatic test_timeout();
        int waits = 0;
        mtvec = 32'h400;
        ex_valid = 1; ex_exc_valid = 1; ex_exc_code = 4'd5; ex_pc = 32'h600; mem_busy = 1;
        tick();
        clear_ex();
        #1;
        while (trap_enter !== 1'b1 && waits < 40) begin
            waits++;
            tick();
        end
        checks++;
        if (waits !== 16 || drain_timeout !== 1'b1) begin
            failures++;
            $display("FAIL timeout_wait waits=%0d dt=%b want 16 1", waits, drain_timeout);
        end
        tick(); tick(); tick();
        checks++;
        if (drain_timeout !== 1'b1 || stall !== 1'b0) begin
            failures++;
            $display("FAIL timeout_sticky dt=%b stall=%b want 1 0", drain_timeout, stall);
        end
        mem_busy = 0;
    endtask

    task automatic test_reset_mid();
        int pulses = 0;
        ex_valid = 1; ex_exc_valid = 1; ex_exc_code = 4'd4; ex_pc = 32'h700; mem_busy = 1;
        tick();
        clear_ex();
        tick();
        rst_n = 0;
        tick();
        checks++;
        if ({trap_enter, mret_exec, stall, flush, redirect_valid, drain_timeout} !== 6'b0 ||
            trap_cause !== 32'd0 || redirect_pc !== 32'd0) begin
            failures++;
            $display("FAIL rstmid_outputs ctrl=%b cause=%h rpc=%h want 000000 0 0",
                     {trap_enter, mret_exec, stall, flush, redirect_valid, drain_timeout},
                     trap_cause, redirect_pc);
        end
        rst_n = 1; mem_busy = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (trap_enter === 1'b1 || redirect_valid === 1'b1) pulses++;
        end
        checks++;
        if (pulses !== 0) begin
            failures++;
            $display("FAIL rstmid_no_pulse pulses=%0d want 0", pulses);
        end
    endtask

    initial begin
        test_reset();
        test_illegal();
        test_timer_irq();
        test_exc_and_irq();
        test_mret_drain();
        test_timeout();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
